minimac3_tx_mii: RTL and testbench

- MII transmit engine for the minimac3 Ethernet MAC; the transmit counterpart of the MII receive path.
- Reads a frame byte-by-byte from a dual-port transmit buffer through a synchronous read port.
- Serialises the frame as nibbles onto the PHY: preamble/SFD, payload, zero padding and FCS.
- Enforces the inter-frame gap, then reports completion to the control logic in the phy_tx_clk domain.

---
 rtl/minimac3_tx_mii.sv | 205 ++++++++++++++++++++
 tb/tb_minimac3_tx_mii.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/minimac3_tx_mii.sv
// MII transmit engine: reads a frame from the TX buffer and sends preamble/SFD, payload, [pad, FCS], then IFG.
// Optional pad-to-minimum and CRC-32 FCS append are built when MINIMAC3_TX_FCS_EN is defined.
module minimac3_tx_mii #(
    parameter int IFG_NIBBLES = 24
`ifdef MINIMAC3_TX_FCS_EN
    , parameter int MIN_PAYLOAD = 60
`endif
) (
    input  logic        phy_tx_clk,
    input  logic        sys_rst,
    input  logic        tx_start,
    input  logic [10:0] tx_count,
    output logic        tx_busy,
    output logic        tx_done,
    output logic [10:0] txb_adr,
    input  logic [7:0]  txb_dat,
    output logic        phy_tx_en,
    output logic [3:0]  phy_tx_data
);

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, DATA_LO, DATA_HI, PAD_LO, PAD_HI, FCS, IFG
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  nib_cnt, nib_nxt;
    logic [10:0] byte_cnt, byte_cnt_nxt;
    logic [10:0] adr_nxt;
    logic [7:0]  byte_reg, byte_reg_nxt;
    logic        busy_nxt, done_nxt, en_nxt;
    logic [3:0]  data_nxt;
    logic        start_ok;

`ifdef MINIMAC3_TX_FCS_EN
    logic [31:0] crc, crc_nxt, fcs_word;
    logic [10:0] tot, tot_nxt;

    // Reflected CRC-32, one byte LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i])
                r = (r >> 1) ^ 32'hEDB88320;
            else
                r = r >> 1;
        end
        return r;
    endfunction

    assign fcs_word = ~crc;
`endif

    assign start_ok = tx_start && (tx_count != 11'd0);

    always_comb begin
        state_nxt    = state;
        nib_nxt      = nib_cnt;
        byte_cnt_nxt = byte_cnt;
        adr_nxt      = txb_adr;
        byte_reg_nxt = byte_reg;
        en_nxt       = 1'b0;
        data_nxt     = 4'h0;
`ifdef MINIMAC3_TX_FCS_EN
        crc_nxt      = crc;
        tot_nxt      = tot;
`endif

        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = PREAMBLE;
                    nib_nxt   = 8'd0;
                end
            end
            PREAMBLE: begin
                if (nib_cnt == 8'd15)
                    state_nxt = DATA_LO;
                else
                    nib_nxt = nib_cnt + 8'd1;
            end
            DATA_LO: state_nxt = DATA_HI;
            DATA_HI: begin
                if (byte_cnt == 11'd0) begin
                    nib_nxt = 8'd0;
`ifdef MINIMAC3_TX_FCS_EN
                    state_nxt = (tot < 11'(MIN_PAYLOAD)) ? PAD_LO : FCS;
`else
                    state_nxt = IFG;
`endif
                end else begin
                    state_nxt = DATA_LO;
                end
            end
`ifdef MINIMAC3_TX_FCS_EN
            PAD_LO: state_nxt = PAD_HI;
            PAD_HI: begin
                nib_nxt   = 8'd0;
                state_nxt = (tot < 11'(MIN_PAYLOAD)) ? PAD_LO : FCS;
            end
            FCS: begin
                if (nib_cnt == 8'd7) begin
                    state_nxt = IFG;
                    nib_nxt   = 8'd0;
                end else begin
                    nib_nxt = nib_cnt + 8'd1;
                end
            end
`endif
            IFG: begin
                // The done cycle doubles as the idle slot, so a waiting start is
                // taken here and the next preamble follows with no extra gap.
                if (nib_cnt == 8'(IFG_NIBBLES - 1)) begin
                    state_nxt = start_ok ? PREAMBLE : IDLE;
                    nib_nxt   = 8'd0;
                end else begin
                    nib_nxt = nib_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Start actions apply on every accepted start, from IDLE or end of IFG.
        if (state_nxt == PREAMBLE && (state == IDLE || state == IFG)) begin
            adr_nxt      = 11'd0;
            byte_cnt_nxt = tx_count;
`ifdef MINIMAC3_TX_FCS_EN
            crc_nxt      = 32'hFFFFFFFF;
            tot_nxt      = 11'd0;
`endif
        end

        // Registered outputs follow the state being entered.
        case (state_nxt)
            PREAMBLE: begin
                en_nxt   = 1'b1;
                data_nxt = (nib_nxt == 8'd15) ? 4'hD : 4'h5;
            end
            DATA_LO: begin
                en_nxt       = 1'b1;
                data_nxt     = txb_dat[3:0];
                byte_reg_nxt = txb_dat;
                adr_nxt      = txb_adr + 11'd1;
                byte_cnt_nxt = byte_cnt - 11'd1;
`ifdef MINIMAC3_TX_FCS_EN
                crc_nxt      = crc_byte(crc, txb_dat);
                tot_nxt      = tot + 11'd1;
`endif
            end
            DATA_HI: begin
                en_nxt   = 1'b1;
                data_nxt = byte_reg[7:4];
            end
`ifdef MINIMAC3_TX_FCS_EN
            PAD_LO: begin
                en_nxt  = 1'b1;
                crc_nxt = crc_byte(crc, 8'h00);
                tot_nxt = tot + 11'd1;
            end
            PAD_HI: en_nxt = 1'b1;
            FCS: begin
                en_nxt   = 1'b1;
                data_nxt = fcs_word[{nib_nxt[2:0], 2'b00} +: 4];
            end
`endif
            default: ;
        endcase

        done_nxt = (state_nxt == IFG) && (nib_nxt == 8'(IFG_NIBBLES - 1));
        busy_nxt = (state_nxt != IDLE) && !done_nxt;
    end

    always_ff @(posedge phy_tx_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            nib_cnt     <= 8'd0;
            byte_cnt    <= 11'd0;
            txb_adr     <= 11'd0;
            byte_reg    <= 8'h00;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            phy_tx_en   <= 1'b0;
            phy_tx_data <= 4'h0;
`ifdef MINIMAC3_TX_FCS_EN
            crc         <= 32'hFFFFFFFF;
            tot         <= 11'd0;
`endif
        end else begin
            state       <= state_nxt;
            nib_cnt     <= nib_nxt;
            byte_cnt    <= byte_cnt_nxt;
            txb_adr     <= adr_nxt;
            byte_reg    <= byte_reg_nxt;
            tx_busy     <= busy_nxt;
            tx_done     <= done_nxt;
            phy_tx_en   <= en_nxt;
            phy_tx_data <= data_nxt;
`ifdef MINIMAC3_TX_FCS_EN
            crc         <= crc_nxt;
            tot         <= tot_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_minimac3_tx_mii.sv
// Directed bench for minimac3_tx_mii: frame content, lengths, IFG, back-to-back, zero count, mid-frame reset.
module tb_minimac3_tx_mii;

    localparam int IFG = 24;
`ifdef MINIMAC3_TX_FCS_EN
    localparam bit FCS_ON = 1'b1;
`else
    localparam bit FCS_ON = 1'b0;
`endif

    logic        phy_tx_clk = 1'b0;
    logic        sys_rst    = 1'b1;
    logic        tx_start   = 1'b0;
    logic [10:0] tx_count   = 11'd0;
    logic        tx_busy, tx_done, phy_tx_en;
    logic [10:0] txb_adr;
    logic [7:0]  txb_dat    = 8'h00;
    logic [3:0]  phy_tx_data;

    logic [7:0]  mem [0:2047];
    logic [3:0]  nibs [$];
    int          tests = 0;
    int          fails = 0;

    always #5 phy_tx_clk = ~phy_tx_clk;

    // Synchronous-read transmit buffer model.
    always @(posedge phy_tx_clk) txb_dat <= mem[txb_adr];

    minimac3_tx_mii dut (
        .phy_tx_clk  (phy_tx_clk),
        .sys_rst     (sys_rst),
        .tx_start    (tx_start),
        .tx_count    (tx_count),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .txb_adr     (txb_adr),
        .txb_dat     (txb_dat),
        .phy_tx_en   (phy_tx_en),
        .phy_tx_data (phy_tx_data)
    );

    task automatic tick();
        @(posedge phy_tx_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic int payload_len(input int n);
        if (FCS_ON && n < 60) return 60;
        return n;
    endfunction

    // Entered at the first sample after the start edge; leaves at the sample after tx_done.
    task automatic run_frame(input string tag, input int n, input bit chain);
        int en_cyc = 0, guard = 0, ifg = 0, dones = 0;
        int adr_bad = 0, pre_adr_bad = 0, pre_bad = 0, dat_bad = 0, nb;
        logic [7:0]  b, e;
        logic [31:0] crc, rev;
        nibs.delete();
        check({tag, " busy"}, 32'(tx_busy), 32'd1);
        while (phy_tx_en && guard < 5000) begin
            nibs.push_back(phy_tx_data);
            if (txb_adr > 11'(n)) adr_bad++;
            if (en_cyc < 16 && txb_adr != 11'd0) pre_adr_bad++;
            if (tx_done) dones++;
            en_cyc++;
            guard++;
            tick();
        end
        check({tag, " en_cycles"}, 32'(en_cyc), 32'(16 + 2 * payload_len(n) + (FCS_ON ? 8 : 0)));
        check({tag, " adr_final"}, 32'(txb_adr), 32'(n));
        check({tag, " adr_range"}, 32'(adr_bad), 32'd0);
        check({tag, " adr_pre"}, 32'(pre_adr_bad), 32'd0);
        check({tag, " done_early"}, 32'(dones), 32'd0);
        while (guard < 5000) begin
            ifg++;
            guard++;
            if (tx_done || phy_tx_en) break;
            tick();
        end
        check({tag, " ifg_len"}, 32'(ifg), 32'(IFG));
        check({tag, " done"}, 32'(tx_done), 32'd1);
        check({tag, " busy_at_done"}, 32'(tx_busy), 32'd0);
        check({tag, " en_at_done"}, 32'(phy_tx_en), 32'd0);
        tick();
        if (chain) begin
            check({tag, " next_en"}, 32'(phy_tx_en), 32'd1);
            check({tag, " next_pre"}, 32'(phy_tx_data), 32'h5);
        end else begin
            check({tag, " done_once"}, 32'(tx_done), 32'd0);
            check({tag, " en_after"}, 32'(phy_tx_en), 32'd0);
        end
        if (nibs.size() >= 16) begin
            for (int i = 0; i < 15; i++) if (nibs[i] != 4'h5) pre_bad++;
            if (nibs[15] != 4'hD) pre_bad++;
            nb  = (nibs.size() - 16) / 2;
            crc = 32'hFFFFFFFF;
            for (int i = 0; i < nb; i++) begin
                b   = {nibs[17 + 2 * i], nibs[16 + 2 * i]};
                crc = crc_byte(crc, b);
                e   = (i < n) ? mem[i] : 8'h00;
                if (i < payload_len(n) && b != e) dat_bad++;
            end
        end else begin
            pre_bad = 1;
        end
        check({tag, " preamble"}, 32'(pre_bad), 32'd0);
        check({tag, " data"}, 32'(dat_bad), 32'd0);
        if (FCS_ON) begin
            rev = {<<{crc}};
            check({tag, " residue"}, rev, 32'hC704DD7B);
        end
    endtask

    task automatic start(input int n, input bit hold);
        tx_count = 11'(n);
        tx_start = 1'b1;
        tick();
        tx_start = hold;
    endtask

    initial begin
        int act;
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i * 37 + 11);

        // Reset state
        repeat (3) tick();
        check("rst busy", 32'(tx_busy), 32'd0);
        check("rst done", 32'(tx_done), 32'd0);
        check("rst adr", 32'(txb_adr), 32'd0);
        check("rst en", 32'(phy_tx_en), 32'd0);
        check("rst data", 32'(phy_tx_data), 32'd0);
        sys_rst = 1'b0;
        tick();

        // Zero-length start is ignored
        start(0, 1'b0);
        act = 0;
        for (int i = 0; i < 40; i++) begin
            if (phy_tx_en || tx_busy || tx_done) act++;
            tick();
        end
        check("zero_count activity", 32'(act), 32'd0);

        // Short frame
        start(5, 1'b0);
        run_frame("f5", 5, 1'b0);
        repeat (3) tick();

        // Back-to-back with tx_start held high
        start(5, 1'b1);
        run_frame("b2b_1", 5, 1'b1);
        tx_start = 1'b0;
        run_frame("b2b_2", 5, 1'b0);
        repeat (3) tick();

        // Reset during DATA_HI of byte 10: wire cycle 16 + 2*10 + 1 = 37
        start(20, 1'b0);
        repeat (37) tick();
        check("mid hi10", 32'(phy_tx_data), 32'(mem[10][7:4]));
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        check("mid_rst en", 32'(phy_tx_en), 32'd0);
        check("mid_rst adr", 32'(txb_adr), 32'd0);
        check("mid_rst busy", 32'(tx_busy), 32'd0);
        check("mid_rst done", 32'(tx_done), 32'd0);
        act = 0;
        for (int i = 0; i < 40; i++) begin
            if (phy_tx_en || tx_busy || tx_done) act++;
            tick();
        end
        check("mid_rst quiet", 32'(act), 32'd0);
        start(5, 1'b0);
        run_frame("post_rst", 5, 1'b0);
        repeat (3) tick();

        // 64-byte frame of 0x00..0x3F
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
        start(64, 1'b0);
        run_frame("f64", 64, 1'b0);
        repeat (3) tick();

        // "123456789"
        for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
        start(9, 1'b0);
        run_frame("f9", 9, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
